// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and periodic modes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   load       capture cnt_in as the current count and the reload value
//   enab       decrement qualifier while running
//   reload_en  periodic mode select, sampled at terminal count
//   cnt_in     start / reload value
//   cnt_out    registered current count
//   busy       high while running
//   done       high once a one-shot count has expired
//   tc         one-cycle terminal-count pulse
//
// All outputs come straight from flops or from a decode of the state flop,
// so no input reaches an output combinationally.
module countdown_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             reload_en,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // load wins over everything, including a terminal count in flight
            cnt_d    = cnt_in;
            reload_d = cnt_in;
            state_d  = (cnt_in != '0) ? RUN : IDLE;
        end else if (state_q == RUN && enab) begin
            if (cnt_q > WIDTH'(1)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                // Terminal count. A zero count in RUN cannot occur (a zero
                // load goes to IDLE), so folding it in here only keeps the
                // counter from ever wrapping.
                tc_d = 1'b1;
                if (reload_en) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
        end
    end

    assign cnt_out = cnt_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign tc      = tc_q;

endmodule
